// File: rtl/gbe_udp_tx_arb.sv
// gbe_udp_tx_arb: round-robin arbiter packing N_CH UDP source channels onto one GbE UDP core TX port.
// Latency: a transferred word appears on app_tx_data one cycle later; one idle cycle arbitrates between packets.
// Backpressure: app_tx_afull drops the owner's ch_ready while sending; the tail of a truncated packet drains regardless.
//
// Ports: app_clk / app_rst_n (synchronous, active-low); ch_data/ch_valid/ch_eof/ch_destip/ch_destport are
// packed per-channel source buses accepted by ch_ready; app_tx_* carry word, valid, eof and destination to
// the core, throttled by app_tx_afull; grant shows the packet owner; pkt_count/trunc_count are statistics.
module gbe_udp_tx_arb #(
    parameter int N_CH       = 4,
    parameter int DATA_WIDTH = 64,
    parameter int MAX_WORDS  = 1024
) (
    input  logic                       app_clk,
    input  logic                       app_rst_n,
    input  logic [N_CH*DATA_WIDTH-1:0] ch_data,
    input  logic [N_CH-1:0]            ch_valid,
    input  logic [N_CH-1:0]            ch_eof,
    input  logic [N_CH*32-1:0]         ch_destip,
    input  logic [N_CH*16-1:0]         ch_destport,
    output logic [N_CH-1:0]            ch_ready,
    output logic [DATA_WIDTH-1:0]      app_tx_data,
    output logic                       app_tx_dvld,
    output logic                       app_tx_eof,
    output logic [31:0]                app_tx_destip,
    output logic [15:0]                app_tx_destport,
    input  logic                       app_tx_afull,
    output logic [N_CH-1:0]            grant,
    output logic [31:0]                pkt_count,
    output logic [15:0]                trunc_count
);

    localparam int          IW        = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam logic [15:0] LAST_WORD = 16'(MAX_WORDS - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SEND  = 2'd1,
        FLUSH = 2'd2
    } state_t;

    state_t                  state_q, state_d;

    // last_grant_q is both the round-robin pointer and the index of the active owner
    logic [IW-1:0]           last_grant_q;
    logic [15:0]             word_cnt_q;

    logic                    pick_vld;
    logic [IW-1:0]           pick_idx;
    logic [N_CH-1:0]         pick_oh;
    logic [31:0]             pick_ip;
    logic [15:0]             pick_port;

    logic                    g_valid;
    logic                    g_eof;
    logic [DATA_WIDTH-1:0]   g_data;

    logic                    start;
    logic                    xfer;
    logic                    at_last;

    // First requester searching upward from last_grant+1, wrapping at N_CH
    always_comb begin
        pick_vld = 1'b0;
        pick_idx = '0;
        for (int i = 1; i <= N_CH; i++) begin
            for (int k = 0; k < N_CH; k++) begin
                if (!pick_vld && ch_valid[k] && (((int'(last_grant_q) + i) % N_CH) == k)) begin
                    pick_vld = 1'b1;
                    pick_idx = IW'(k);
                end
            end
        end
    end

    // Candidate destination for the pick, and the owner's live source signals
    always_comb begin
        pick_oh   = '0;
        pick_ip   = '0;
        pick_port = '0;
        g_valid   = 1'b0;
        g_eof     = 1'b0;
        g_data    = '0;
        for (int k = 0; k < N_CH; k++) begin
            if (pick_idx == IW'(k)) begin
                pick_oh[k] = 1'b1;
                pick_ip    = ch_destip[k*32 +: 32];
                pick_port  = ch_destport[k*16 +: 16];
            end
            if (last_grant_q == IW'(k)) begin
                g_valid = ch_valid[k];
                g_eof   = ch_eof[k];
                g_data  = ch_data[k*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign at_last = (word_cnt_q == LAST_WORD);

    always_comb begin
        state_d  = state_q;
        ch_ready = '0;
        start    = 1'b0;
        xfer     = 1'b0;
        case (state_q)
            IDLE: begin
                if (pick_vld && !app_tx_afull) begin
                    start   = 1'b1;
                    state_d = SEND;
                end
            end
            SEND: begin
                ch_ready = grant & {N_CH{~app_tx_afull}};
                xfer     = g_valid & ~app_tx_afull;
                if (xfer && g_eof) begin
                    state_d = IDLE;
                end else if (xfer && at_last) begin
                    state_d = FLUSH;
                end
            end
            FLUSH: begin
                // Tail of an overlong packet is swallowed; the core is not involved
                ch_ready = grant;
                if (g_valid && g_eof) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge app_clk) begin
        if (!app_rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge app_clk) begin
        if (!app_rst_n) begin
            last_grant_q    <= IW'(N_CH - 1);
            grant           <= '0;
            word_cnt_q      <= '0;
            app_tx_data     <= '0;
            app_tx_dvld     <= 1'b0;
            app_tx_eof      <= 1'b0;
            app_tx_destip   <= '0;
            app_tx_destport <= '0;
            pkt_count       <= '0;
            trunc_count     <= '0;
        end else begin
            app_tx_dvld <= xfer;
            // word MAX_WORDS closes the frame on the wire even without a source eof
            app_tx_eof  <= xfer & (g_eof | at_last);
            if (xfer) begin
                app_tx_data <= g_data;
            end

            if (start) begin
                last_grant_q    <= pick_idx;
                grant           <= pick_oh;
                app_tx_destip   <= pick_ip;
                app_tx_destport <= pick_port;
                word_cnt_q      <= '0;
            end else if (xfer) begin
                word_cnt_q <= word_cnt_q + 16'd1;
            end

            if (state_q != IDLE && state_d == IDLE) begin
                grant <= '0;
            end

            if (xfer && (g_eof | at_last)) begin
                pkt_count <= pkt_count + 32'd1;
            end
            if (xfer && !g_eof && at_last && trunc_count != 16'hFFFF) begin
                trunc_count <= trunc_count + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_gbe_udp_tx_arb.sv
// tb_gbe_udp_tx_arb: directed scenarios plus randomized traffic against a packet-level reference model.
// Latency: model expects each accepted word on the core side one cycle after its handshake.
// Backpressure: app_tx_afull and source valid gaps are driven randomly or scripted per scenario.
module tb_gbe_udp_tx_arb;

    localparam int N_CH = 4;
    localparam int DW   = 64;
    localparam int MW   = 4;

    logic                 app_clk = 1'b0;
    logic                 app_rst_n;
    logic [N_CH*DW-1:0]   ch_data;
    logic [N_CH-1:0]      ch_valid;
    logic [N_CH-1:0]      ch_eof;
    logic [N_CH*32-1:0]   ch_destip;
    logic [N_CH*16-1:0]   ch_destport;
    logic [N_CH-1:0]      ch_ready;
    logic [DW-1:0]        app_tx_data;
    logic                 app_tx_dvld;
    logic                 app_tx_eof;
    logic [31:0]          app_tx_destip;
    logic [15:0]          app_tx_destport;
    logic                 app_tx_afull;
    logic [N_CH-1:0]      grant;
    logic [31:0]          pkt_count;
    logic [15:0]          trunc_count;

    gbe_udp_tx_arb #(.N_CH(N_CH), .DATA_WIDTH(DW), .MAX_WORDS(MW)) dut (
        .app_clk         (app_clk),
        .app_rst_n       (app_rst_n),
        .ch_data         (ch_data),
        .ch_valid        (ch_valid),
        .ch_eof          (ch_eof),
        .ch_destip       (ch_destip),
        .ch_destport     (ch_destport),
        .ch_ready        (ch_ready),
        .app_tx_data     (app_tx_data),
        .app_tx_dvld     (app_tx_dvld),
        .app_tx_eof      (app_tx_eof),
        .app_tx_destip   (app_tx_destip),
        .app_tx_destport (app_tx_destport),
        .app_tx_afull    (app_tx_afull),
        .grant           (grant),
        .pkt_count       (pkt_count),
        .trunc_count     (trunc_count)
    );

    always #5 app_clk = ~app_clk;

    int n_vec = 0;
    int n_err = 0;

    // Sources: per-channel word queues, bit DW is the eof marker
    logic [DW:0]    src_q [N_CH][$];
    logic [31:0]    dest_ip   [N_CH];
    logic [15:0]    dest_port [N_CH];
    bit             rand_dest = 1'b0;
    int             pkt_seq   = 0;

    // Reference model state
    int             widx [N_CH];     // words of the current packet already taken from each channel
    int             m_last;
    logic [N_CH-1:0] m_grant;
    logic [31:0]    m_ip;
    logic [15:0]    m_port;
    logic [31:0]    m_pkt;
    logic [15:0]    m_trunc;
    bit             exp_dvld;
    bit             exp_eof;
    logic [DW-1:0]  exp_data;
    logic [N_CH-1:0] prev_req;
    bit             prev_afull;
    bit             prev_end;
    logic [31:0]    prev_ip   [N_CH];
    logic [15:0]    prev_port [N_CH];

    logic [DW-1:0]  out_log [$];
    logic [DW-1:0]  ref_w [$];
    int             grant_log [$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int rr_pick(input logic [N_CH-1:0] req, input int last);
        for (int i = 1; i <= N_CH; i++) begin
            if (req[(last + i) % N_CH]) return (last + i) % N_CH;
        end
        return -1;
    endfunction

    function automatic int oh_idx(input logic [N_CH-1:0] v);
        for (int i = 0; i < N_CH; i++) begin
            if (v[i]) return i;
        end
        return -1;
    endfunction

    function automatic int q_words();
        int s = 0;
        for (int i = 0; i < N_CH; i++) s += src_q[i].size();
        return s;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N_CH; i++) begin
            widx[i] = 0;
            src_q[i].delete();
        end
        m_last     = N_CH - 1;
        m_grant    = '0;
        m_ip       = '0;
        m_port     = '0;
        m_pkt      = '0;
        m_trunc    = '0;
        exp_dvld   = 1'b0;
        exp_eof    = 1'b0;
        exp_data   = '0;
        prev_req   = '0;
        prev_afull = 1'b0;
        prev_end   = 1'b0;
    endtask

    task automatic push_pkt(input int k, input int len);
        for (int i = 0; i < len; i++) begin
            src_q[k].push_back({(i == len - 1), 8'(k), 24'(pkt_seq), 32'($urandom)});
        end
        pkt_seq++;
    endtask

    task automatic snap_ref(input int k);
        logic [DW:0] w;
        ref_w.delete();
        for (int i = 0; i < src_q[k].size(); i++) begin
            w = src_q[k][i];
            ref_w.push_back(w[DW-1:0]);
        end
    endtask

    // Compare registered outputs against what the previous cycle's handshakes imply
    task automatic chk_outs();
        logic [N_CH-1:0] g_exp;
        int p;
        p = 0;
        chk("tx_dvld", 64'(app_tx_dvld), 64'(exp_dvld));
        chk("tx_eof", 64'(app_tx_eof), 64'(exp_dvld & exp_eof));
        if (exp_dvld) chk("tx_data", app_tx_data, exp_data);
        if (app_tx_dvld) out_log.push_back(app_tx_data);
        g_exp = '0;
        if (m_grant == '0) begin
            if (prev_req != '0 && !prev_afull) begin
                p        = rr_pick(prev_req, m_last);
                g_exp[p] = 1'b1;
                m_last   = p;
                m_ip     = prev_ip[p];
                m_port   = prev_port[p];
            end
        end else if (!prev_end) begin
            g_exp = m_grant;
        end
        chk("grant", 64'(grant), 64'(g_exp));
        if (m_grant == '0 && g_exp != '0) grant_log.push_back(p);
        m_grant = g_exp;
        chk("destip", 64'(app_tx_destip), 64'(m_ip));
        chk("destport", 64'(app_tx_destport), 64'(m_port));
        chk("pkt_count", 64'(pkt_count), 64'(m_pkt));
        chk("trunc_count", 64'(trunc_count), 64'(m_trunc));
    endtask

    task automatic step(input int gap_pct, input int afull_pct);
        logic [N_CH-1:0] v, xv, exp_rdy;
        logic [DW:0] w;
        int k, g;
        @(negedge app_clk);
        chk_outs();
        v = '0;
        for (int c = 0; c < N_CH; c++) begin
            if (rand_dest) begin
                dest_ip[c]   = $urandom;
                dest_port[c] = 16'($urandom);
            end
            ch_destip[c*32 +: 32]   = dest_ip[c];
            ch_destport[c*16 +: 16] = dest_port[c];
            prev_ip[c]              = dest_ip[c];
            prev_port[c]            = dest_port[c];
            ch_data[c*DW +: DW]     = '0;
            ch_eof[c]               = 1'b0;
            if (src_q[c].size() > 0 && $urandom_range(99) >= gap_pct) begin
                w                   = src_q[c][0];
                v[c]                = 1'b1;
                ch_data[c*DW +: DW] = w[DW-1:0];
                ch_eof[c]           = w[DW];
            end
        end
        ch_valid     = v;
        app_tx_afull = ($urandom_range(99) < afull_pct);
        #1;
        exp_rdy = '0;
        g = oh_idx(m_grant);
        if (g >= 0) exp_rdy[g] = (widx[g] >= MW) ? 1'b1 : ~app_tx_afull;
        chk("ch_ready", 64'(ch_ready), 64'(exp_rdy));

        xv         = ch_ready & v;
        k          = oh_idx(xv);
        prev_req   = v;
        prev_afull = app_tx_afull;
        prev_end   = 1'b0;
        exp_dvld   = 1'b0;
        exp_eof    = 1'b0;
        if (k >= 0) begin
            w = src_q[k][0];
            if (widx[k] < MW) begin
                exp_dvld = 1'b1;
                exp_data = w[DW-1:0];
                exp_eof  = w[DW] || (widx[k] == MW - 1);
                if (exp_eof) m_pkt++;
                if (!w[DW] && widx[k] == MW - 1 && m_trunc != 16'hFFFF) m_trunc++;
            end
            widx[k]++;
            if (w[DW]) begin
                widx[k]  = 0;
                prev_end = 1'b1;
            end
        end
        @(posedge app_clk);
        if (k >= 0) void'(src_q[k].pop_front());
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (q_words() > 0 && n < 2000) begin
            step(0, 0);
            n++;
        end
        chk("drain_timeout", 64'(n >= 2000), 64'(0));
        repeat (3) step(0, 0);
        #1;
    endtask

    task automatic do_reset(input bit pre);
        @(negedge app_clk);
        if (pre) chk_outs();
        app_rst_n = 1'b0;
        @(posedge app_clk);
        @(negedge app_clk);
        chk("rst_dvld", 64'(app_tx_dvld), 64'(0));
        chk("rst_eof", 64'(app_tx_eof), 64'(0));
        chk("rst_data", app_tx_data, 64'(0));
        chk("rst_grant", 64'(grant), 64'(0));
        chk("rst_destip", 64'(app_tx_destip), 64'(0));
        chk("rst_destport", 64'(app_tx_destport), 64'(0));
        chk("rst_pkt_count", 64'(pkt_count), 64'(0));
        chk("rst_trunc_count", 64'(trunc_count), 64'(0));
        chk("rst_ready", 64'(ch_ready), 64'(0));
        app_rst_n    = 1'b1;
        ch_valid     = '0;
        app_tx_afull = 1'b0;
        model_reset();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int c;
        app_rst_n    = 1'b0;
        ch_valid     = '1;
        ch_eof       = '0;
        ch_data      = '0;
        ch_destip    = '0;
        ch_destport  = '0;
        app_tx_afull = 1'b0;
        for (int i = 0; i < N_CH; i++) begin
            dest_ip[i]   = 32'hC0A80010 + 32'(i);
            dest_port[i] = 16'(1000 + i);
        end
        model_reset();
        repeat (2) @(posedge app_clk);
        do_reset(1'b0);

        // Three-word packet on channel 0 with a fixed destination
        dest_ip[0]   = 32'h0a000001;
        dest_port[0] = 16'hC350;
        out_log.delete();
        push_pkt(0, 3);
        snap_ref(0);
        drain();
        chk("t3w_nwords", 64'(out_log.size()), 64'(3));
        for (int i = 0; i < 3 && i < out_log.size(); i++) chk("t3w_word", out_log[i], ref_w[i]);
        chk("t3w_pkts", 64'(pkt_count), 64'(1));
        chk("t3w_destip", 64'(app_tx_destip), 64'(32'h0a000001));
        chk("t3w_destport", 64'(app_tx_destport), 64'(16'hC350));

        // All channels busy with 2-word packets: round-robin order
        do_reset(1'b1);
        grant_log.delete();
        push_pkt(0, 2); push_pkt(1, 2); push_pkt(2, 2); push_pkt(3, 2); push_pkt(0, 2);
        drain();
        chk("rr_ngrants", 64'(grant_log.size()), 64'(5));
        for (int i = 0; i < 5 && i < grant_log.size(); i++) chk("rr_order", 64'(grant_log[i]), 64'(i % 4));
        chk("rr_pkts", 64'(pkt_count), 64'(5));

        // Overlong packet on channel 2 is truncated to MW words
        do_reset(1'b1);
        out_log.delete();
        push_pkt(2, 6);
        snap_ref(2);
        drain();
        chk("trunc_nwords", 64'(out_log.size()), 64'(MW));
        for (int i = 0; i < MW && i < out_log.size(); i++) chk("trunc_word", out_log[i], ref_w[i]);
        chk("trunc_count_end", 64'(trunc_count), 64'(1));
        chk("trunc_pkts", 64'(pkt_count), 64'(1));
        chk("trunc_idle", 64'(grant), 64'(0));

        // Core almost-full for three cycles mid-packet
        do_reset(1'b1);
        out_log.delete();
        push_pkt(1, 3);
        snap_ref(1);
        step(0, 0);
        step(0, 0);
        repeat (3) step(0, 100);
        drain();
        chk("afull_nwords", 64'(out_log.size()), 64'(3));
        for (int i = 0; i < 3 && i < out_log.size(); i++) chk("afull_word", out_log[i], ref_w[i]);
        chk("afull_pkts", 64'(pkt_count), 64'(1));

        // Reset while word 2 is offered, then channel 0 wins first again
        do_reset(1'b1);
        push_pkt(0, 4);
        step(0, 0);
        step(0, 0);
        do_reset(1'b1);
        grant_log.delete();
        for (int i = 0; i < N_CH; i++) push_pkt(i, 1);
        drain();
        chk("rst_ngrants", 64'(grant_log.size()), 64'(N_CH));
        if (grant_log.size() > 0) chk("rst_first_grant", 64'(grant_log[0]), 64'(0));
        chk("rst_pkts", 64'(pkt_count), 64'(N_CH));

        // Randomized traffic, destinations churning every cycle
        rand_dest = 1'b1;
        for (int cyc = 0; cyc < 1500; cyc++) begin
            if ($urandom_range(99) < 15) begin
                c = $urandom_range(N_CH - 1);
                if (src_q[c].size() < 12) push_pkt(c, $urandom_range(7, 1));
            end
            step(20, 20);
        end
        drain();
        rand_dest = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
